parity_stream_checker: RTL and testbench

//   Streaming, multi-lane parity checker/regenerator with a valid/ready handshake.
//   - Checks each DATA_W-bit lane of an accepted beat against its received parity
//     bit, in odd or even mode.
//   - Forwards the data with freshly generated parity and a per-lane error flag.
//   - Keeps a saturating error-beat counter and a sticky error flag.
//   - Sits between a link receiver and downstream consumers.

---
 rtl/parity_pkg.sv | 21 ++
 rtl/parity_lane_check.sv | 23 ++
 rtl/parity_stream_checker.sv | 156 +++++++++++++++
 tb/tb_parity_stream_checker.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared types, mode encodings and the per-lane parity helper for parity_stream_checker.
// The helper zero-extends each lane to MAX_LANE_W bits; zero padding never changes parity.
package parity_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic MODE_ODD   = 1'b1;
    localparam logic MODE_EVEN  = 1'b0;
    localparam int   MAX_LANE_W = 64;

    // Parity bit that makes {parity, data} satisfy the requested mode.
    function automatic logic lane_parity(input logic [MAX_LANE_W-1:0] data,
                                         input logic                  mode);
        return (mode == MODE_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/parity_lane_check.sv
// Combinational single-lane parity check and parity regeneration.
// DATA_W must not exceed parity_pkg::MAX_LANE_W.
module parity_lane_check
    import parity_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] lane,
    input  logic              par_in,
    input  logic              odd_mode,
    output logic              err,
    output logic              par_out
);

    logic x;

    always_comb begin
        x       = ^{par_in, lane};
        err     = (odd_mode == MODE_ODD) ? ~x : x;
        par_out = lane_parity(MAX_LANE_W'(lane), odd_mode);
    end

endmodule

// File: rtl/parity_stream_checker.sv
// Multi-lane streaming parity checker/regenerator with a two-entry skid buffer,
// saturating error-beat counter and sticky error flag. Optional macro PARITY_ERR_INJECT_EN
// adds an inj_err input that inverts the stored m_par[0] of an accepted beat.
module parity_stream_checker
    import parity_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    odd_mode,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [LANES*DATA_W-1:0] s_data,
    input  logic [LANES-1:0]        s_par,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [LANES*DATA_W-1:0] m_data,
    output logic [LANES-1:0]        m_par,
    output logic [LANES-1:0]        m_err,
    output logic [CNT_W-1:0]        err_cnt,
    output logic                    err_sticky,
    input  logic                    clr
`ifdef PARITY_ERR_INJECT_EN
    ,
    input  logic                    inj_err
`endif
);

    typedef struct packed {
        logic [LANES*DATA_W-1:0] data;
        logic [LANES-1:0]        par;
        logic [LANES-1:0]        err;
    } beat_t;

    state_t          state_q, state_d;
    beat_t           main_q, main_d;
    beat_t           skid_q, skid_d;
    beat_t           in_beat;
    logic            s_ready_q, s_ready_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic            err_sticky_q, err_sticky_d;

    logic [LANES-1:0] lane_err;
    logic [LANES-1:0] lane_par;
    logic             accept;
    logic             emit;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        parity_lane_check #(
            .DATA_W (DATA_W)
        ) u_lane_check (
            .lane     (s_data[i*DATA_W +: DATA_W]),
            .par_in   (s_par[i]),
            .odd_mode (odd_mode),
            .err      (lane_err[i]),
            .par_out  (lane_par[i])
        );
    end

    always_comb begin
        in_beat.data = s_data;
        in_beat.par  = lane_par;
        in_beat.err  = lane_err;
`ifdef PARITY_ERR_INJECT_EN
        // Corrupts only the forwarded parity; the error view stays truthful.
        in_beat.par[0] = lane_par[0] ^ inj_err;
`endif
    end

    assign m_valid    = (state_q != EMPTY);
    assign s_ready    = s_ready_q;
    assign m_data     = main_q.data;
    assign m_par      = main_q.par;
    assign m_err      = main_q.err;
    assign err_cnt    = err_cnt_q;
    assign err_sticky = err_sticky_q;

    assign accept = s_valid & s_ready_q;
    assign emit   = m_valid & m_ready;

    // NOTE: every always_comb output is given a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_d  = in_beat;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && emit) begin
                    main_d = in_beat;
                end else if (accept) begin
                    skid_d  = in_beat;
                    state_d = TWO;
                end else if (emit) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // s_ready is low here, so only the output side can move.
                if (emit) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase

        s_ready_d = (state_d != TWO);
    end

    always_comb begin
        err_cnt_d    = err_cnt_q;
        err_sticky_d = err_sticky_q;
        if (clr) begin
            err_cnt_d    = '0;
            err_sticky_d = 1'b0;
        end else if (accept && (|lane_err)) begin
            err_sticky_d = 1'b1;
            if (err_cnt_q != {CNT_W{1'b1}}) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: the data registers are reset too, because m_data/m_par/m_err must read zero
    // out of reset; a reset-free datapath would be cheaper but would violate that.
    // NOTE: state is updated with non-blocking assignments only, so all flops sample
    // the same pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= EMPTY;
            main_q       <= '0;
            skid_q       <= '0;
            s_ready_q    <= 1'b1;
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
            s_ready_q    <= s_ready_d;
            err_cnt_q    <= err_cnt_d;
            err_sticky_q <= err_sticky_d;
        end
    end

endmodule

// File: tb/tb_parity_stream_checker.sv
// Randomized self-checking bench: a queue-based reference model of the two-deep stream,
// with parity judged by counting ones. A second instance with CNT_W=2 exercises saturation.
module tb_parity_stream_checker;

    localparam int DATA_W = 8;
    localparam int LANES  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        odd_mode;
    logic        s_valid;
    logic [31:0] s_data;
    logic [3:0]  s_par;
    logic        m_ready;
    logic        clr;
    logic        inj_err;

    logic        s_ready, m_valid, err_sticky;
    logic [31:0] m_data;
    logic [3:0]  m_par, m_err;
    logic [15:0] err_cnt;

    logic        s_ready2, m_valid2, err_sticky2;
    logic [31:0] m_data2;
    logic [3:0]  m_par2, m_err2;
    logic [1:0]  err_cnt2;

    always #5 clk = ~clk;

    parity_stream_checker #(.DATA_W(DATA_W), .LANES(LANES), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .odd_mode(odd_mode), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_par(s_par), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_par(m_par), .m_err(m_err), .err_cnt(err_cnt),
        .err_sticky(err_sticky), .clr(clr)
`ifdef PARITY_ERR_INJECT_EN
        , .inj_err(inj_err)
`endif
    );

    parity_stream_checker #(.DATA_W(DATA_W), .LANES(LANES), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .odd_mode(odd_mode), .s_valid(s_valid), .s_ready(s_ready2),
        .s_data(s_data), .s_par(s_par), .m_valid(m_valid2), .m_ready(m_ready),
        .m_data(m_data2), .m_par(m_par2), .m_err(m_err2), .err_cnt(err_cnt2),
        .err_sticky(err_sticky2), .clr(clr)
`ifdef PARITY_ERR_INJECT_EN
        , .inj_err(inj_err)
`endif
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  par;
        logic [3:0]  err;
    } exp_beat_t;

    exp_beat_t q[$];
    int        model_cnt;
    logic      model_sticky;
    int        n_checks;
    int        n_fail;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_beat_t make_beat(input logic [31:0] d, input logic [3:0] p,
                                            input logic mode, input logic inj);
        exp_beat_t b;
        b.data = d;
        for (int i = 0; i < LANES; i++) begin
            logic [7:0] lane;
            int         ones;
            lane = d[i*DATA_W +: DATA_W];
            ones = $countones(lane);
            // Odd mode wants an odd total number of ones over data+parity.
            b.par[i] = mode ? ((ones % 2) == 0) : ((ones % 2) == 1);
            b.err[i] = mode ? (((ones + int'(p[i])) % 2) == 0)
                            : (((ones + int'(p[i])) % 2) == 1);
        end
`ifdef PARITY_ERR_INJECT_EN
        if (inj) b.par[0] = ~b.par[0];
`else
        if (inj) b.par = b.par;
`endif
        return b;
    endfunction

    task automatic check_outputs();
        int exp16, exp2;
        exp16 = (model_cnt > 65535) ? 65535 : model_cnt;
        exp2  = (model_cnt > 3) ? 3 : model_cnt;
        check("m_valid", 64'(m_valid), 64'(q.size() > 0));
        check("s_ready", 64'(s_ready), 64'(q.size() < 2));
        if (q.size() > 0) begin
            check("m_data", 64'(m_data), 64'(q[0].data));
            check("m_par",  64'(m_par),  64'(q[0].par));
            check("m_err",  64'(m_err),  64'(q[0].err));
        end
        check("err_cnt",     64'(err_cnt),     64'(exp16));
        check("err_sticky",  64'(err_sticky),  64'(model_sticky));
        check("err_cnt_sat", 64'(err_cnt2),    64'(exp2));
        check("sticky_sat",  64'(err_sticky2), 64'(model_sticky));
    endtask

    // One clock of stimulus: drive after the falling edge, check, then advance the model.
    task automatic step(input logic v, input logic [31:0] d, input logic [3:0] p,
                        input logic mode, input logic mr, input logic c, input logic inj);
        exp_beat_t b;
        logic      acc, emt;
        @(negedge clk);
        s_valid  = v;
        s_data   = d;
        s_par    = p;
        odd_mode = mode;
        m_ready  = mr;
        clr      = c;
        inj_err  = inj;
        #1;
        check_outputs();
        acc = v && (q.size() < 2);
        emt = (q.size() > 0) && mr;
        b   = make_beat(d, p, mode, inj);
        if (emt) void'(q.pop_front());
        if (c) begin
            model_cnt    = 0;
            model_sticky = 1'b0;
        end else if (acc && (b.err != 4'b0)) begin
            model_cnt++;
            model_sticky = 1'b1;
        end
        if (acc) q.push_back(b);
    endtask

    task automatic idle(input int n, input logic mr);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 4'h0, 1'b0, mr, 1'b0, 1'b0);
    endtask

    initial begin
        logic mode;
        n_checks = 0; n_fail = 0; model_cnt = 0; model_sticky = 1'b0;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_par = '0; odd_mode = 1'b0;
        m_ready = 1'b0; clr = 1'b0; inj_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", 64'(s_ready), 64'd1);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data",  64'(m_data),  64'd0);
        check("rst_m_par",   64'(m_par),   64'd0);
        check("rst_m_err",   64'(m_err),   64'd0);
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
        check("rst_sticky",  64'(err_sticky), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Odd-mode directed beat, then an even-mode single-lane error.
        step(1'b1, 32'h01_03_00_FF, 4'b1010, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 32'h00_07_00_00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1);

        // Backpressure: two beats fill the buffer and must hold, then drain in order.
        step(1'b1, 32'hA5A5_0001, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h5A5A_0002, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hDEAD_BEEF, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        idle(3, 1'b1);

        // Five error beats saturate the narrow counter; clr wins over a coincident error.
        for (int i = 0; i < 5; i++)
            step(1'b1, 32'h0000_0001 << i, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1, 1'b1);
        check("sat_cnt2_is_3", 64'(err_cnt2), 64'd3);
        step(1'b1, 32'h0000_0001, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1, 1'b1);
        check("clr_cnt_zero", 64'(err_cnt), 64'd0);
        check("clr_sticky_zero", 64'(err_sticky), 64'd0);

`ifdef PARITY_ERR_INJECT_EN
        // Clean even-mode beat with injection: only the forwarded parity bit 0 flips.
        step(1'b1, 32'h0000_0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(1, 1'b1);
`endif

        // Random traffic with occasional mode flips, clears and stalls.
        mode = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            step($urandom_range(0, 3) != 0, $urandom, 4'($urandom), mode,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0,
                 $urandom_range(0, 7) == 0);
        end
        idle(3, 1'b1);

        // Asynchronous reset with two beats buffered: discarded at once, nothing emerges.
        step(1'b1, 32'h1111_1111, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h2222_2222, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        check("pre_rst_full", 64'(s_ready), 64'd0);
        #1 rst = 1'b1;
        #1;
        check("arst_m_valid", 64'(m_valid), 64'd0);
        check("arst_s_ready", 64'(s_ready), 64'd1);
        check("arst_err_cnt", 64'(err_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        model_cnt = 0;
        model_sticky = 1'b0;
        idle(4, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
